acc_cpu: RTL

ACC_CPU -- requirements
Module: acc_cpu

---
 rtl/acc_cpu_pkg.sv | 53 +++++
 rtl/acc_cpu_alu.sv | 25 ++
 rtl/acc_cpu_reg.sv | 18 +
 rtl/acc_cpu.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, FSM state encodings,
// ALU operation codes and the parameter legality check.
package acc_cpu_pkg;

   localparam int unsigned OP_WIDTH    = 4;
   localparam int unsigned STATE_WIDTH = 4;
   localparam int unsigned ALU_WIDTH   = 3;

   typedef enum logic [OP_WIDTH-1:0] {
      OP_LD   = 4'h0,
      OP_ST   = 4'h1,
      OP_ADD  = 4'h2,
      OP_SUB  = 4'h3,
      OP_AND  = 4'h4,
      OP_NOT  = 4'h5,
      OP_IN   = 4'h6,
      OP_OUT  = 4'h7,
      OP_JMP  = 4'h8,
      OP_JZ   = 4'h9,
      OP_PUSH = 4'hA,
      OP_POP  = 4'hB,
      OP_NOPC = 4'hC,
      OP_NOPD = 4'hD,
      OP_NOPE = 4'hE,
      OP_STOP = 4'hF
   } opcode_t;

   typedef enum logic [STATE_WIDTH-1:0] {
      S_FETCH  = 4'd0,
      S_WAIT_I = 4'd1,
      S_DECODE = 4'd2,
      S_READ   = 4'd3,
      S_WAIT_D = 4'd4,
      S_EXEC   = 4'd5,
      S_WRITE  = 4'd6,
      S_IO     = 4'd7,
      S_STOP   = 4'd8
   } state_t;

   typedef enum logic [ALU_WIDTH-1:0] {
      ALU_PASS = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_NOT  = 3'd4
   } alu_op_t;

   // The opcode field sits above the address field, so the word must hold both.
   function automatic bit widths_legal(int unsigned aw, int unsigned dw);
      return (aw > 0) && (dw >= aw + OP_WIDTH);
   endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: pass operand, add, subtract, and, invert accumulator.
module acc_cpu_alu
   import acc_cpu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [ALU_WIDTH-1:0] op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [WIDTH-1:0]     result_c
);

   always_comb begin
      result_c = b;
      case (op)
         ALU_PASS: result_c = b;
         ALU_ADD:  result_c = a + b;
         ALU_SUB:  result_c = a - b;
         ALU_AND:  result_c = a & b;
         ALU_NOT:  result_c = ~a;
         default:  result_c = b;
      endcase
   end

endmodule

// File: rtl/acc_cpu_reg.sv
// Loadable register with synchronous active-high reset to a fixed value.
module acc_cpu_reg #(
   parameter int unsigned     WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)     q <= RST_VAL;
      else if (en) q <= d;
   end

endmodule

// File: rtl/acc_cpu.sv
// Multi-cycle accumulator CPU with synchronous external memory, a stack
// pointer and valid/ready input and output word ports.
module acc_cpu
   import acc_cpu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned PC_START   = 8,
   parameter int unsigned SP_START   = 2**ADDR_WIDTH - 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] mem_in,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] sp,
   output logic [DATA_WIDTH-1:0] acc,
   output logic                  halted,
   output logic [STATE_WIDTH-1:0] state
);

   if (!widths_legal(ADDR_WIDTH, DATA_WIDTH)) begin : g_bad_widths
      $fatal(1, "acc_cpu: DATA_WIDTH must be at least ADDR_WIDTH+4");
   end

   state_t                cur, nxt;
   logic [DATA_WIDTH-1:0] ir, alu_y;
   logic                  pc_en, sp_en, acc_en, ir_en;
   logic [ADDR_WIDTH-1:0] pc_d, sp_d, mem_addr_d;
   logic [DATA_WIDTH-1:0] acc_d, mem_data_d, out_d;
   logic                  mem_we_d, in_ready_d, out_valid_d, halted_d;
   opcode_t               dec_op, ir_op, alu_src;
   alu_op_t               alu_op;
   logic [ADDR_WIDTH-1:0] dec_a, ir_a;
   logic                  unused_bits;

   assign dec_op      = opcode_t'(mem_in[DATA_WIDTH-1 -: OP_WIDTH]);
   assign ir_op       = opcode_t'(ir[DATA_WIDTH-1 -: OP_WIDTH]);
   assign dec_a       = mem_in[ADDR_WIDTH-1:0];
   assign ir_a        = ir[ADDR_WIDTH-1:0];
   assign state       = cur;
   assign unused_bits = ^{ir, mem_in};

   acc_cpu_reg #(.WIDTH(ADDR_WIDTH), .RST_VAL(ADDR_WIDTH'(PC_START))) u_pc
      (.clk(clk), .rst(rst), .en(pc_en), .d(pc_d), .q(pc));
   acc_cpu_reg #(.WIDTH(ADDR_WIDTH), .RST_VAL(ADDR_WIDTH'(SP_START))) u_sp
      (.clk(clk), .rst(rst), .en(sp_en), .d(sp_d), .q(sp));
   acc_cpu_reg #(.WIDTH(DATA_WIDTH), .RST_VAL('0)) u_acc
      (.clk(clk), .rst(rst), .en(acc_en), .d(acc_d), .q(acc));
   acc_cpu_reg #(.WIDTH(DATA_WIDTH), .RST_VAL('0)) u_ir
      (.clk(clk), .rst(rst), .en(ir_en), .d(mem_in), .q(ir));

   // NOT finishes in DECODE before IR is loaded, so the opcode comes from mem_in there.
   always_comb begin
      alu_src = (cur == S_DECODE) ? dec_op : ir_op;
      case (alu_src)
         OP_ADD:  alu_op = ALU_ADD;
         OP_SUB:  alu_op = ALU_SUB;
         OP_AND:  alu_op = ALU_AND;
         OP_NOT:  alu_op = ALU_NOT;
         default: alu_op = ALU_PASS;
      endcase
   end

   acc_cpu_alu #(.WIDTH(DATA_WIDTH)) u_alu
      (.op(alu_op), .a(acc), .b(mem_in), .result_c(alu_y));

   always_comb begin
      nxt         = cur;
      pc_en       = 1'b0;
      pc_d        = pc + ADDR_WIDTH'(1);
      sp_en       = 1'b0;
      sp_d        = sp;
      acc_en      = 1'b0;
      acc_d       = alu_y;
      ir_en       = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr;
      mem_data_d  = mem_data;
      in_ready_d  = 1'b0;
      out_d       = out;
      out_valid_d = 1'b0;
      halted_d    = halted;
      case (cur)
         S_FETCH: begin
            mem_addr_d = pc;
            pc_en      = 1'b1;
            nxt        = S_WAIT_I;
         end
         S_WAIT_I: nxt = S_DECODE;
         S_DECODE: begin
            ir_en = 1'b1;
            nxt   = S_FETCH;
            case (dec_op)
               OP_LD, OP_ADD, OP_SUB, OP_AND: nxt = S_READ;
               OP_POP: begin
                  sp_en = 1'b1;
                  sp_d  = sp + ADDR_WIDTH'(1);
                  nxt   = S_READ;
               end
               OP_ST, OP_PUSH: begin
                  mem_we_d   = 1'b1;
                  mem_addr_d = (dec_op == OP_PUSH) ? sp : dec_a;
                  mem_data_d = acc;
                  nxt        = S_WRITE;
               end
               OP_NOT: acc_en = 1'b1;
               OP_IN: begin
                  in_ready_d = 1'b1;
                  nxt        = S_IO;
               end
               OP_OUT: begin
                  out_d       = acc;
                  out_valid_d = 1'b1;
                  nxt         = S_IO;
               end
               OP_JMP: begin
                  pc_en = 1'b1;
                  pc_d  = dec_a;
               end
               OP_JZ: begin
                  pc_en = (acc == '0);
                  pc_d  = dec_a;
               end
               OP_STOP: begin
                  halted_d = 1'b1;
                  nxt      = S_STOP;
               end
               default: nxt = S_FETCH;
            endcase
         end
         S_READ: begin
            mem_addr_d = (ir_op == OP_POP) ? sp : ir_a;
            nxt        = S_WAIT_D;
         end
         S_WAIT_D: nxt = S_EXEC;
         S_EXEC: begin
            acc_en = 1'b1;
            nxt    = S_FETCH;
         end
         S_WRITE: begin
            sp_en = (ir_op == OP_PUSH);
            sp_d  = sp - ADDR_WIDTH'(1);
            nxt   = S_FETCH;
         end
         S_IO: begin
            if (ir_op == OP_IN) begin
               if (in_valid) begin
                  acc_en = 1'b1;
                  acc_d  = in;
                  nxt    = S_FETCH;
               end else begin
                  in_ready_d = 1'b1;
               end
            end else if (out_ready) begin
               nxt = S_FETCH;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         S_STOP: nxt = S_STOP;
         default: nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur       <= S_FETCH;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_data  <= '0;
         in_ready  <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
         halted    <= 1'b0;
      end else begin
         cur       <= nxt;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_data  <= mem_data_d;
         in_ready  <= in_ready_d;
         out       <= out_d;
         out_valid <= out_valid_d;
         halted    <= halted_d;
      end
   end

endmodule
